sha1_wb_master: RTL and testbench
=================================

Name: sha1_wb_master

Overview:
- Wishbone initiator that drives the SHA1 Wishbone peripheral end to end: ID check, engine reset, 16 message-word writes, done polling, 5 digest reads.
- Sits beside a local controller (CPU-less datapath or test harness) that supplies one 512-bit block and takes back the 160-bit digest.
- Sequential core: transaction FSM, word/poll counters, single-outstanding-cycle Wishbone handshake.

Parameters:
- SLAVE_BASE, 32'h30000024, base address of the SHA1 peripheral; registers are at +0x0 NR, +0x4 ID, +0x8 OPS, +0xC MSG_IN, +0x10 DIGEST.
- POLL_GAP, 8, idle cycles between successive OPS polls (at least 1).
- ACK_TIMEOUT, 255, cycles to wait for wbm_ack_i before aborting (used only with the optional feature).

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle pulse; ignored unless idle or done/error.
- msg_i  in  512  block; sampled on the accepted start_i; word k = msg_i[32k+31:32k].
- digest_o  out  160  result; word k = digest_o[32k+31:32k].
- busy_o  out  1  high from accepted start until done/error.
- done_o  out  1  sticky until next accepted start.
- err_o  out  1  sticky until next accepted start.
- err_code_o  out  2  0 none, 1 ID mismatch, 2 engine panic, 3 ack timeout.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone master controls.
- wbm_sel_o  out  4  always 4'hF while stb is high, else 0.
- wbm_adr_o, wbm_dat_o  out  32 each  address / write data.
- wbm_dat_i  in  32  read data, valid when wbm_ack_i is high.
- wbm_ack_i  in  1  transfer acknowledge.

Behaviour:
- Reset (asynchronous, wb_rst_ni low): state IDLE; all outputs 0; msg and digest registers 0; counters 0.
- Bus rule: one transfer at a time.
  - cyc and stb rise together and are held with adr, we and dat stable until the cycle where ack=1 is sampled.
  - cyc and stb then drop for at least one cycle before the next transfer; the slave counts on this ack gap.
  - Read data is captured on the ack cycle.
- States:
  - IDLE: on start_i, latch msg_i, clear done_o/err_o/err_code_o, set busy_o, go to CHKID.
  - CHKID: read base+0x4. If data is not 32'h53484131, go to ERR with code 1; otherwise go to CTRL.
  - CTRL: write base+0x8 with 32'h2 (reset=1, on=0), then go to MSG with word idx=0.
  - MSG: write base+0xC with word idx, idx 0..15. Ack data other than 32'h1 goes to ERR with code 2. After idx 15 is acked, go to GAP.
  - GAP: wait POLL_GAP cycles, then go to POLL.
  - POLL: read base+0x8. Bit2 set: ERR with code 2. Bit3 set: DIGEST with idx=0. Otherwise back to GAP. Bits [10:4] (loop index) are ignored.
  - DIGEST: read base+0x10 five times and store word idx. Ack data 32'hfffffff0 (busy) goes to ERR with code 2.
  - DONE: busy_o=0, done_o=1, digest_o valid. start_i restarts the sequence.
  - ERR: busy_o=0, err_o=1, bus idle. start_i restarts the sequence.
- start_i while busy: ignored; no effect on the latched msg.
- Reset mid-transfer: bus signals drop immediately (asynchronously); no partial digest is retained.
- Minimum latency, zero-wait slave with ack one cycle after stb, POLL_GAP=P, N polls: 2 cycles per transfer, so 2×(1+1+16+N+5) + N×P cycles.

Optional Feature:
- Macro: SHA1_WBM_TIMEOUT_EN.
- Defined: an 8..16-bit counter runs while stb is high and waits for ack. Reaching ACK_TIMEOUT cycles drops cyc/stb and goes to ERR with code 3.
- Not defined: the master waits for ack forever, and code 3 is never produced.

Test Plan:
- "abc" block (w0=32'h61626380, w15=32'h00000018, others 0) against the real SHA1 slave -> done_o=1, err_o=0; digest words are a9993e36, 4706816a, ba3e2571, 7850c26c, 9cd0d89d in the slave's read order (digest_o[31:0] is the first read); exactly 16 MSG_IN writes are observed.
- Bus-functional model returns ID 32'hdeadbeef -> err_o=1, err_code_o=1; no write to base+0x8 is ever issued.
- Model sets OPS bit2 on the third poll -> err_code_o=2; no DIGEST reads.
- Model holds ack low for 300 cycles with TIMEOUT_EN defined and ACK_TIMEOUT=255 -> cyc drops 255 cycles after stb rises; err_code_o=3.
- Assert wb_rst_ni low in the middle of the 8th MSG write -> cyc/stb/busy_o are 0 in the same cycle; a new start_i completes correctly.
- Protocol checker over every run: stb never deasserts before ack; at least one idle cycle between transfers; sel=4'hF throughout every transfer; start_i pulses while busy have no effect.

Source files
------------

// File: rtl/sha1_wb_master.sv
// Wishbone initiator that pushes one 512-bit block through the SHA1 peripheral and reads back the digest.
// Optional ack watchdog: define SHA1_WBM_TIMEOUT_EN to abort a transfer that is never acknowledged.
module sha1_wb_master #(
  parameter logic [31:0] SLAVE_BASE  = 32'h3000_0024,
  parameter int unsigned POLL_GAP    = 8,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_ni,
  input  logic         start_i,
  input  logic [511:0] msg_i,
  output logic [159:0] digest_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o,
  output logic [1:0]   err_code_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i
);

  localparam logic [31:0] ADR_ID   = SLAVE_BASE + 32'h4;
  localparam logic [31:0] ADR_OPS  = SLAVE_BASE + 32'h8;
  localparam logic [31:0] ADR_MSG  = SLAVE_BASE + 32'hC;
  localparam logic [31:0] ADR_DIG  = SLAVE_BASE + 32'h10;
  localparam logic [31:0] SHA1_ID  = 32'h5348_4131;
  localparam logic [31:0] DIG_BUSY = 32'hFFFF_FFF0;
  localparam logic [31:0] OPS_RST  = 32'h0000_0002;

  localparam int unsigned GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(POLL_GAP - 1);

  if (POLL_GAP < 1 || ACK_TIMEOUT < 1) begin : g_param_check
    $fatal(1, "sha1_wb_master: POLL_GAP and ACK_TIMEOUT must be at least 1");
  end

  typedef enum logic [3:0] {
    S_IDLE, S_CHKID, S_CTRL, S_MSG, S_GAP, S_POLL, S_DIGEST, S_DONE, S_ERR
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_ID    = 2'd1,
    ERR_PANIC = 2'd2,
    ERR_TMO   = 2'd3
  } err_e;

  state_e             state_q, state_d;
  logic               stb_q, stb_d;
  logic [3:0]         idx_q, idx_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [511:0]       msg_q, msg_d;
  logic [159:0]       digest_q, digest_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  err_e               err_code_q, err_code_d;

  logic               req_we;
  logic [31:0]        req_adr;
  logic [31:0]        req_dat;
  logic               bus_state;
  logic               ack_seen;
  logic               fail;
  err_e               fail_code;

`ifdef SHA1_WBM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);
  logic [15:0] tmo_q, tmo_d;
`endif

  // Request fields depend only on state/idx, both frozen while stb is high.
  always_comb begin
    req_we  = 1'b0;
    req_adr = '0;
    req_dat = '0;
    case (state_q)
      S_CHKID:  req_adr = ADR_ID;
      S_CTRL: begin
        req_we  = 1'b1;
        req_adr = ADR_OPS;
        req_dat = OPS_RST;
      end
      S_MSG: begin
        req_we  = 1'b1;
        req_adr = ADR_MSG;
        req_dat = msg_q[{idx_q, 5'd0} +: 32];
      end
      S_POLL:   req_adr = ADR_OPS;
      S_DIGEST: req_adr = ADR_DIG;
      default: ;
    endcase
  end

  assign bus_state = state_q inside {S_CHKID, S_CTRL, S_MSG, S_POLL, S_DIGEST};
  assign ack_seen  = stb_q && wbm_ack_i;

  // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    stb_d      = stb_q;
    idx_d      = idx_q;
    gap_d      = gap_q;
    msg_d      = msg_q;
    digest_d   = digest_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
`ifdef SHA1_WBM_TIMEOUT_EN
    tmo_d      = '0;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          msg_d      = msg_i;
          digest_d   = '0;
          done_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          busy_d     = 1'b1;
          state_d    = S_CHKID;
        end
      end
      S_CHKID: begin
        if (ack_seen) begin
          if (wbm_dat_i != SHA1_ID) begin
            fail      = 1'b1;
            fail_code = ERR_ID;
          end else begin
            state_d = S_CTRL;
          end
        end
      end
      S_CTRL: begin
        if (ack_seen) begin
          idx_d   = '0;
          state_d = S_MSG;
        end
      end
      S_MSG: begin
        if (ack_seen) begin
          if (wbm_dat_i != 32'h1) begin
            fail      = 1'b1;
            fail_code = ERR_PANIC;
          end else if (idx_q == 4'd15) begin
            gap_d   = '0;
            state_d = S_GAP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = S_POLL;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      S_POLL: begin
        // Bits [10:4] carry the engine's round counter and are irrelevant here.
        if (ack_seen) begin
          if (wbm_dat_i[2]) begin
            fail      = 1'b1;
            fail_code = ERR_PANIC;
          end else if (wbm_dat_i[3]) begin
            idx_d   = '0;
            state_d = S_DIGEST;
          end else begin
            gap_d   = '0;
            state_d = S_GAP;
          end
        end
      end
      S_DIGEST: begin
        if (ack_seen) begin
          if (wbm_dat_i == DIG_BUSY) begin
            fail      = 1'b1;
            fail_code = ERR_PANIC;
          end else begin
            digest_d[{idx_q[2:0], 5'd0} +: 32] = wbm_dat_i;
            if (idx_q == 4'd4) begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Launch from an idle bus, drop on ack: guarantees one idle cycle between transfers.
    if (bus_state) begin
      if (!stb_q) begin
        stb_d = 1'b1;
      end else if (wbm_ack_i) begin
        stb_d = 1'b0;
      end
    end

`ifdef SHA1_WBM_TIMEOUT_EN
    if (stb_q && !wbm_ack_i) begin
      if (tmo_q == TMO_LAST) begin
        stb_d     = 1'b0;
        fail      = 1'b1;
        fail_code = ERR_TMO;
      end else begin
        tmo_d = tmo_q + 16'd1;
      end
    end
`endif

    if (fail) begin
      busy_d     = 1'b0;
      err_d      = 1'b1;
      err_code_d = fail_code;
      state_d    = S_ERR;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q    <= S_IDLE;
      stb_q      <= 1'b0;
      idx_q      <= '0;
      gap_q      <= '0;
      // NOTE: the block and digest storage is reset too, so no stale digest survives a reset.
      msg_q      <= '0;
      digest_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef SHA1_WBM_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      stb_q      <= stb_d;
      idx_q      <= idx_d;
      gap_q      <= gap_d;
      msg_q      <= msg_d;
      digest_q   <= digest_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef SHA1_WBM_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  assign wbm_cyc_o  = stb_q;
  assign wbm_stb_o  = stb_q;
  assign wbm_we_o   = stb_q & req_we;
  assign wbm_sel_o  = stb_q ? 4'hF : 4'h0;
  assign wbm_adr_o  = stb_q ? req_adr : '0;
  assign wbm_dat_o  = stb_q ? req_dat : '0;

  assign digest_o   = digest_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_sha1_wb_master.sv
// Self-checking bench for sha1_wb_master: SHA1 peripheral bus model with a behavioural SHA1 reference
// and an always-on Wishbone protocol monitor.
module tb_sha1_wb_master;

  localparam logic [31:0] BASE  = 32'h3000_0024;
  localparam logic [31:0] A_ID  = BASE + 32'h4;
  localparam logic [31:0] A_OPS = BASE + 32'h8;
  localparam logic [31:0] A_MSG = BASE + 32'hC;
  localparam logic [31:0] A_DIG = BASE + 32'h10;

  logic         wb_clk_i = 1'b0;
  logic         wb_rst_ni;
  logic         start_i;
  logic [511:0] msg_i;
  logic [159:0] digest_o;
  logic         busy_o, done_o, err_o;
  logic [1:0]   err_code_o;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o;
  logic [31:0]  wbm_dat_i;
  logic         wbm_ack_i;

  sha1_wb_master dut (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_ni  (wb_rst_ni),
    .start_i    (start_i),
    .msg_i      (msg_i),
    .digest_o   (digest_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .err_code_o (err_code_o),
    .wbm_cyc_o  (wbm_cyc_o),
    .wbm_stb_o  (wbm_stb_o),
    .wbm_we_o   (wbm_we_o),
    .wbm_sel_o  (wbm_sel_o),
    .wbm_adr_o  (wbm_adr_o),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_ack_i  (wbm_ack_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Straight textbook SHA1 compression of one block from the standard initial state.
  function automatic logic [159:0] sha1_ref(input logic [511:0] m);
    logic [31:0] w [80];
    logic [31:0] a, b, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
    for (int i = 16; i < 80; i++) begin
      t    = w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16];
      w[i] = {t[30:0], t[31]};
    end
    a = 32'h67452301; b = 32'hEFCDAB89; c = 32'h98BADCFE; d = 32'h10325476; e = 32'hC3D2E1F0;
    for (int i = 0; i < 80; i++) begin
      if (i < 20)      begin f = (b & c) | (~b & d);          k = 32'h5A827999; end
      else if (i < 40) begin f = b ^ c ^ d;                   k = 32'h6ED9EBA1; end
      else if (i < 60) begin f = (b & c) | (b & d) | (c & d); k = 32'h8F1BBCDC; end
      else             begin f = b ^ c ^ d;                   k = 32'hCA62C1D6; end
      t = {a[26:0], a[31:27]} + f + e + k + w[i];
      e = d; d = c; c = {b[1:0], b[31:2]}; b = a; a = t;
    end
    return {32'hC3D2E1F0 + e, 32'h10325476 + d, 32'h98BADCFE + c, 32'hEFCDAB89 + b, 32'h67452301 + a};
  endfunction

  // Peripheral model configuration and observation counters.
  logic [31:0]  id_val;
  int           done_at, poll_err_at;
  bit           msg_bad, dig_busy, stall;
  int           msg_writes, ops_writes, dig_reads, polls, wcount, didx;
  logic [31:0]  words [16];
  logic [159:0] h_val;

  // Monitor state from the previous falling edge.
  logic         p_stb = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [31:0]  p_adr = '0, p_dat = '0;
  bit           rst_hit = 1'b0;

  always @(negedge wb_rst_ni) rst_hit = 1'b1;

  task automatic bfm_clear();
    id_val = 32'h5348_4131; done_at = 1; poll_err_at = 0;
    msg_bad = 0; dig_busy = 0; stall = 0;
    msg_writes = 0; ops_writes = 0; dig_reads = 0; polls = 0; wcount = 0; didx = 0;
  endtask

  task automatic bfm_respond();
    logic [511:0] blk;
    logic [31:0]  junk;
    wbm_dat_i = '0;
    junk = {21'd0, 7'(polls + 1), 4'd0};
    case (wbm_adr_o)
      A_ID: if (!wbm_we_o) wbm_dat_i = id_val;
      A_OPS: begin
        if (wbm_we_o) begin
          ops_writes++;
          if (wbm_dat_o[1]) begin wcount = 0; polls = 0; didx = 0; end
        end else begin
          polls++;
          if (polls == poll_err_at)  wbm_dat_i = junk | 32'h4;
          else if (polls >= done_at) wbm_dat_i = junk | 32'h8;
          else                       wbm_dat_i = junk;
        end
      end
      A_MSG: if (wbm_we_o) begin
        msg_writes++;
        if (wcount < 16) words[wcount] = wbm_dat_o;
        wcount++;
        if (wcount == 16) begin
          for (int i = 0; i < 16; i++) blk[32*i +: 32] = words[i];
          h_val = sha1_ref(blk);
        end
        wbm_dat_i = msg_bad ? 32'h0 : 32'h1;
      end
      A_DIG: if (!wbm_we_o) begin
        dig_reads++;
        wbm_dat_i = dig_busy ? 32'hFFFF_FFF0 : h_val[32*didx +: 32];
        didx = (didx + 1) % 5;
      end
      default: ;
    endcase
  endtask

  // Protocol monitor plus zero-wait slave, both on the falling edge, away from the DUT's edge.
  always @(negedge wb_clk_i) begin
    if (!wb_rst_ni || rst_hit) begin
      rst_hit   = 1'b0;
      wbm_ack_i = 1'b0;
      p_stb     = 1'b0;
      p_ack     = 1'b0;
    end else begin
      check("cyc_eq_stb", wbm_cyc_o, wbm_stb_o);
      check("sel", wbm_sel_o, wbm_stb_o ? 4'hF : 4'h0);
      if (p_ack) begin
        check("idle_after_ack", wbm_stb_o, 1'b0);
      end else if (p_stb) begin
        check("stb_held", wbm_stb_o, 1'b1);
        check("req_stable", {wbm_we_o, wbm_adr_o, wbm_dat_o}, {p_we, p_adr, p_dat});
      end
      if (wbm_ack_i) begin
        wbm_ack_i = 1'b0;
      end else if (wbm_stb_o && !stall) begin
        bfm_respond();
        wbm_ack_i = 1'b1;
      end
      p_stb = wbm_stb_o; p_ack = wbm_ack_i; p_we = wbm_we_o;
      p_adr = wbm_adr_o; p_dat = wbm_dat_o;
    end
  end

  task automatic pulse_start(input logic [511:0] m);
    @(posedge wb_clk_i); #1;
    start_i = 1'b1; msg_i = m;
    @(posedge wb_clk_i); #1;
    start_i = 1'b0;
  endtask

  // Runs one block; optionally pokes start_i with a different block while busy.
  task automatic run(input string tag, input logic [511:0] m, input bit poke, output int cycles);
    pulse_start(m);
    check({tag, "_busy"}, busy_o, 1'b1);
    cycles = 0;
    while (!(done_o || err_o) && cycles < 3000) begin
      @(posedge wb_clk_i); #1;
      cycles++;
      if (poke && cycles == 5) begin start_i = 1'b1; msg_i = ~m; end
      else start_i = 1'b0;
    end
    check({tag, "_finished"}, done_o | err_o, 1'b1);
  endtask

  logic [511:0] m;
  int           cyc;
  bit           found;

  initial begin
    wb_rst_ni = 1'b0; start_i = 1'b0; msg_i = '0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
    h_val = '0;
    bfm_clear();
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_err", {err_o, err_code_o}, 3'd0);
    check("rst_digest", digest_o, 160'd0);
    check("rst_bus", {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o}, '0);
    wb_rst_ni = 1'b1;

    // "abc" block with first-poll completion: minimum latency 2*(1+1+16+1+5)+8 = 56.
    m = '0; m[31:0] = 32'h6162_6380; m[511:480] = 32'h0000_0018;
    run("abc", m, 1'b1, cyc);
    check("abc_done", {done_o, err_o, busy_o}, 3'b100);
    check("abc_digest", digest_o,
          {32'h9cd0d89d, 32'h7850c26c, 32'hba3e2571, 32'h4706816a, 32'ha9993e36});
    check("abc_msg_writes", 32'(msg_writes), 32'd16);
    check("abc_ops_writes", 32'(ops_writes), 32'd1);
    check("abc_dig_reads", 32'(dig_reads), 32'd5);
    check("abc_latency", 32'(cyc), 32'd56);

    for (int r = 0; r < 3; r++) begin
      bfm_clear();
      done_at = int'($urandom_range(1, 4));
      for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
      run("rand", m, 1'b1, cyc);
      check("rand_done", {done_o, err_o, err_code_o}, 4'b1000);
      check("rand_digest", digest_o, sha1_ref(m));
      check("rand_polls", 32'(polls), 32'(done_at));
    end

    bfm_clear();
    id_val = 32'hDEAD_BEEF;
    run("badid", m, 1'b0, cyc);
    check("badid_err", {done_o, err_o, err_code_o, busy_o}, 5'b01010);
    check("badid_no_ops", 32'(ops_writes + msg_writes), 32'd0);

    bfm_clear();
    done_at = 10; poll_err_at = 3;
    run("panic", m, 1'b1, cyc);
    check("panic_err", {done_o, err_o, err_code_o}, 4'b0110);
    check("panic_polls", 32'(polls), 32'd3);
    check("panic_no_dig", 32'(dig_reads), 32'd0);

    bfm_clear();
    msg_bad = 1'b1;
    run("msgack", m, 1'b0, cyc);
    check("msgack_err", {err_o, err_code_o}, 3'b110);
    check("msgack_writes", 32'(msg_writes), 32'd1);

    bfm_clear();
    dig_busy = 1'b1;
    run("digbusy", m, 1'b1, cyc);
    check("digbusy_err", {done_o, err_o, err_code_o}, 4'b0110);
    check("digbusy_reads", 32'(dig_reads), 32'd1);

    // Reset asserted while the 8th MSG_IN write is on the bus.
    bfm_clear();
    for (int i = 0; i < 16; i++) m[32*i +: 32] = $urandom;
    pulse_start(m);
    found = 0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(posedge wb_clk_i); #1;
      found = wbm_stb_o && wbm_adr_o == A_MSG && msg_writes == 7;
    end
    check("rst_mid_found", found, 1'b1);
    wb_rst_ni = 1'b0;
    #1;
    check("rst_mid_bus", {wbm_cyc_o, wbm_stb_o, busy_o}, 3'b000);
    check("rst_mid_state", {done_o, err_o, digest_o}, '0);
    @(posedge wb_clk_i); #1;
    wb_rst_ni = 1'b1;
    bfm_clear();
    done_at = 2;
    run("after_rst", m, 1'b1, cyc);
    check("after_rst_done", {done_o, err_o}, 2'b10);
    check("after_rst_digest", digest_o, sha1_ref(m));
    check("after_rst_writes", 32'(msg_writes), 32'd16);

`ifdef SHA1_WBM_TIMEOUT_EN
    bfm_clear();
    stall = 1'b1;
    pulse_start(m);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (wbm_stb_o) found = 1;
      else begin @(posedge wb_clk_i); #1; end
    end
    check("tmo_stb_rose", found, 1'b1);
    cyc = 0;
    while (wbm_stb_o && cyc < 400) begin
      @(posedge wb_clk_i); #1;
      cyc++;
    end
    check("tmo_cycles", 32'(cyc), 32'd255);
    check("tmo_err", {err_o, err_code_o, busy_o}, 4'b1110);
    stall = 1'b0;
`endif

    repeat (3) @(posedge wb_clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
